// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D requesters, the shared memory port and the arbiter.
// The arbiter takes the slave view; whoever drives requests and memory responses takes the master view.
interface mem_arbiter_if;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] data_in;
  logic        busy;
  logic        grant_d;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    output i_resp_valid, i_resp_data, d_resp_valid, d_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
    input  mem_resp_valid, data_in,
    output busy, grant_d
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    input  i_resp_valid, i_resp_data, d_resp_valid, d_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
    output mem_resp_valid, data_in,
    input  busy, grant_d
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto one memory port, one transaction at a time.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; default is fixed D priority.
module mem_arbiter (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
);

  // state      | meaning
  // ST_IDLE    | no transaction, arbitrate pending requests
  // ST_ISSUE   | one-cycle mem_req_valid pulse from registered request
  // ST_WAIT    | waiting for mem_resp_valid, capture data_in
  // ST_RESP    | one-cycle resp_valid to the owner
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]  state;
  logic        owner_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic        pick_d;
  logic        any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_d;
`endif

  assign any_req = bus.i_req_valid | bus.d_req_valid;

  always_comb begin
    pick_d = bus.d_req_valid;
`ifdef ARB_ROUND_ROBIN_EN
    // on a tie, the requester not served last gets the port
    if (bus.i_req_valid && bus.d_req_valid) begin
      pick_d = ~last_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      owner_d <= 1'b0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d  <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner_d <= pick_d;
            addr_q  <= pick_d ? bus.d_req_addr : bus.i_req_addr;
            we_q    <= pick_d & bus.d_req_we;
            wdata_q <= pick_d ? bus.d_req_wdata : 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  <= pick_d;
`endif
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.mem_resp_valid) begin
            data_q <= bus.data_in;
            state  <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid = (state == ST_ISSUE);
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_wdata = wdata_q;

  assign bus.i_resp_valid  = (state == ST_RESP) & ~owner_d;
  assign bus.d_resp_valid  = (state == ST_RESP) &  owner_d;
  assign bus.i_resp_data   = data_q;
  assign bus.d_resp_data   = data_q;

  assign bus.busy          = (state != ST_IDLE);
  assign bus.grant_d       = owner_d;

endmodule
